// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha sequencer: command encodings, FSM states
// and the byte lengths of each parameter and keystream block.
package chacha_pkg;

    localparam logic [1:0] OP_KEY     = 2'd0;
    localparam logic [1:0] OP_NONCE   = 2'd1;
    localparam logic [1:0] OP_COUNTER = 2'd2;
    localparam logic [1:0] OP_GEN     = 2'd3;

    localparam int KEY_LEN = 32;
    localparam int NNC_LEN = 8;
    localparam int CTR_LEN = 8;
    localparam int BLK_LEN = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WAIT_BLK = 3'd3,
        ST_READ     = 3'd4,
        ST_DRAIN    = 3'd5
    } state_e;

    function automatic logic [5:0] op_len(input logic [1:0] op);
        case (op)
            OP_KEY:     op_len = 6'(KEY_LEN);
            OP_NONCE:   op_len = 6'(NNC_LEN);
            default:    op_len = 6'(CTR_LEN);
        endcase
    endfunction

endpackage

// File: rtl/chacha_seq_if.sv
// Command, parameter-byte and keystream-byte channels of the sequencer.
// Every channel: a beat transfers on a rising edge where valid and ready are both
// high; valid never waits for ready, and a raised valid holds its data until it transfers.
interface chacha_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_nblk;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_nblk, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_nblk, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/chacha_obuf.sv
// 64-byte keystream buffer: filled by a contiguous write burst from the core,
// emptied one byte per accepted handshake through the read index.
module chacha_obuf
    import chacha_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic       i_rd_ack,
    output logic [7:0] o_rd_data,
    output logic       o_wr_last,
    output logic       o_rd_last
);

    logic [7:0] r_mem [BLK_LEN];
    logic [5:0] r_widx;
    logic [5:0] r_ridx;

    // Both indices wrap 63 -> 0, so a finished block leaves them ready for the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_widx <= 6'd0;
            r_ridx <= 6'd0;
        end else begin
            if (i_wr_en) r_widx <= r_widx + 6'd1;
            if (i_rd_ack) r_ridx <= r_ridx + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_widx] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_ridx];
    assign o_wr_last = (r_widx == 6'd63);
    assign o_rd_last = (r_ridx == 6'd63);

endmodule

// File: rtl/chacha_seq.sv
// Sequencer between byte streams and a ChaCha core: stages parameter bytes for
// gap-free core writes and buffers each 64-byte keystream block for handshaked output.
module chacha_seq
    import chacha_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    chacha_seq_if.slave   io_bus,
    output logic          o_busy,
    output logic          o_core_wr_key,
    output logic          o_core_wr_nnc,
    output logic          o_core_wr_ctr,
    output logic          o_core_rd_blk,
    output logic          o_core_hold,
    output logic [7:0]    o_core_data_in,
    input  logic          i_core_blk_ready,
    input  logic [7:0]    i_core_data_out,
    output state_e        o_dbg_state
);

    localparam logic [7:0] LAT_INIT = 8'(RD_LAT - 1);

    state_e      r_state;
    logic [1:0]  r_op;
    logic [5:0]  r_len;
    logic [5:0]  r_idx;
    logic [16:0] r_rem;
    logic [7:0]  r_lat;
    logic [7:0]  r_stage [KEY_LEN];

    logic        w_cmd_fire;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_cap;
    logic        w_first_wr;
    logic        w_wr_last;
    logic        w_rd_last;
    logic [7:0]  w_rd_data;

    assign w_cmd_fire = io_bus.cmd_valid & io_bus.cmd_ready;
    assign w_in_fire  = io_bus.in_valid & io_bus.in_ready;
    assign w_out_fire = io_bus.out_valid & io_bus.out_ready;
    assign w_cap      = (r_state == ST_READ) && (r_lat == 8'd0);
    assign w_first_wr = (r_state == ST_WRITE) && (r_idx == 6'd0);

    assign io_bus.cmd_ready = (r_state == ST_IDLE) & ~rst;
    assign io_bus.in_ready  = (r_state == ST_FILL);
    assign io_bus.out_valid = (r_state == ST_DRAIN);
    assign io_bus.out_data  = (r_state == ST_DRAIN) ? w_rd_data : 8'h00;

    assign o_busy         = (r_state != ST_IDLE);
    assign o_core_hold    = !((r_state == ST_WAIT_BLK) || (r_state == ST_READ));
    assign o_core_wr_key  = w_first_wr && (r_op == OP_KEY);
    assign o_core_wr_nnc  = w_first_wr && (r_op == OP_NONCE);
    assign o_core_wr_ctr  = w_first_wr && (r_op == OP_COUNTER);
    assign o_core_rd_blk  = (r_state == ST_WAIT_BLK) && i_core_blk_ready;
    assign o_core_data_in = (r_state == ST_WRITE) ? r_stage[r_idx[4:0]] : 8'h00;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= 2'd0;
            r_len   <= 6'd0;
            r_idx   <= 6'd0;
            r_rem   <= 17'd0;
            r_lat   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_op  <= io_bus.cmd_op;
                        r_idx <= 6'd0;
                        if (io_bus.cmd_op == OP_GEN) begin
                            r_rem   <= (io_bus.cmd_nblk == 16'd0) ? 17'h10000 : {1'b0, io_bus.cmd_nblk};
                            r_state <= ST_WAIT_BLK;
                        end else begin
                            r_len   <= op_len(io_bus.cmd_op);
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_in_fire) begin
                        r_idx <= r_idx + 6'd1;
                        if (r_idx == r_len - 6'd1) begin
                            r_idx   <= 6'd0;
                            r_state <= ST_WRITE;
                        end
                    end
                end
                // The core takes one byte per cycle without stalling, hence the staging.
                ST_WRITE: begin
                    r_idx <= r_idx + 6'd1;
                    if (r_idx == r_len - 6'd1) begin
                        r_idx   <= 6'd0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_BLK: begin
                    if (i_core_blk_ready) begin
                        r_lat   <= LAT_INIT;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_lat != 8'd0) r_lat <= r_lat - 8'd1;
                    else if (w_wr_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_out_fire && w_rd_last) begin
                        r_rem   <= r_rem - 17'd1;
                        r_state <= (r_rem == 17'd1) ? ST_IDLE : ST_WAIT_BLK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_FILL) && w_in_fire) r_stage[r_idx[4:0]] <= io_bus.in_data;
    end

    chacha_obuf u_obuf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_cap),
        .i_wr_data (i_core_data_out),
        .i_rd_ack  (w_out_fire),
        .o_rd_data (w_rd_data),
        .o_wr_last (w_wr_last),
        .o_rd_last (w_rd_last)
    );

endmodule

// File: doc/chacha_seq.md
CHACHA_SEQ -- requirements
Module: chacha_seq

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from the core_rd_blk pulse until byte 0 appears on core_data_out.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid, cmd_ready  in/out  1  command handshake; transfer occurs when both are high.
REQ-005 cmd_op  in  2  command: 0=KEY (32 B), 1=NONCE (8 B), 2=COUNTER (8 B), 3=GEN.
REQ-006 cmd_nblk  in  16  number of blocks for GEN; a value of 0 means 65536.
REQ-007 in_valid, in_ready, in_data  in/out/in  1/1/8  parameter byte stream.
REQ-008 out_valid, out_ready, out_data  out/in/out  1/1/8  keystream byte stream.
REQ-009 busy  out  1  high whenever the FSM is not in IDLE.
REQ-010 core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk  out  1  one-cycle start strobes to the core.
REQ-011 core_hold  out  1  pauses core computation.
REQ-012 core_data_in  out  8  write byte to the core.
REQ-013 core_blk_ready, core_data_out  in  1/8  core block-ready flag and read byte.

Function
REQ-014 The FSM SHALL have the states IDLE, FILL, WRITE, WAIT_BLK, READ and DRAIN.
REQ-015 IDLE: cmd_ready=1; a KEY, NONCE or COUNTER command SHALL go to FILL with len=32/8/8; GEN SHALL latch cmd_nblk into rem (17 bits) and go to WAIT_BLK.
REQ-016 FILL: in_ready=1; each accepted byte SHALL be stored in stage[idx], idx++; once len bytes are held, go to WRITE; no timeout.
REQ-017 WRITE: strobe high only in the first cycle; core_data_in=stage[k] in cycle k for k=0..len-1 with no gaps; then go to IDLE.
REQ-018 Writes SHALL be byte-contiguous because the core does not stall; this is why the write data is staged first.
REQ-019 WAIT_BLK: core_hold=0; when core_blk_ready=1, pulse core_rd_blk for one cycle and go to READ.
REQ-020 READ: capture 64 bytes into obuf[0..63], starting RD_LAT cycles after the pulse, one byte per cycle; then go to DRAIN.
REQ-021 DRAIN: out_valid=1, out_data=obuf[ridx]; ridx++ on each handshake; after byte 63 is accepted, rem--; go to WAIT_BLK if rem≠0, else IDLE.
REQ-022 core_hold SHALL be 1 in every state except WAIT_BLK and READ.
REQ-023 Outside the defined windows, in_ready, cmd_ready, out_valid and all core strobes SHALL be 0, and core_data_in SHALL be 0.
REQ-024 Byte order SHALL be unchanged: stream byte n maps to core byte n.
REQ-025 Indices are 6-bit; ridx wraps from 63 to 0 at the end of a block.
REQ-026 cmd_valid SHALL be ignored while not in IDLE; no command is queued.
REQ-027 out_valid SHALL stay high with out_data stable until out_ready is seen.

Reset
REQ-028 Asserting rst in any state, including mid-burst, SHALL immediately force IDLE and clear idx, ridx, rem and all strobes.
REQ-029 Reset values: cmd_ready=0 while rst is high and 1 after release; in_ready=0, out_valid=0, busy=0, core_hold=1, core_data_in=0.
REQ-030 Buffer contents SHALL NOT be reset.

Structure
REQ-031 The shared package chacha_pkg SHALL hold the op encodings, the state enum, and the constants KEY_LEN=32, NNC_LEN=8, CTR_LEN=8, BLK_LEN=64.
REQ-032 A single sub-module chacha_obuf (64x8 write-burst/read-handshake buffer with ridx) SHALL be used.
REQ-033 The staging buffer SHALL be inline, 32x8.
REQ-034 chacha_seq SHALL instantiate the chacha core in the wrapper above it, not internally.

Verification
REQ-035 KEY: bytes 0x00..0x1F sent with random in_valid gaps -> core_wr_key high for exactly 1 cycle, then 32 contiguous core_data_in bytes 0x00..0x1F; afterwards busy=0.
REQ-036 NONCE then COUNTER, 8 bytes each -> core_wr_nnc and core_wr_ctr each pulse once; bytes arrive in order; no overlap between the two bursts.
REQ-037 GEN nblk=2 with a core model producing bytes 0x40+i -> out stream is 128 bytes (0x40..0x7F twice); core_rd_blk pulses exactly twice; core_hold=1 during DRAIN.
REQ-038 GEN nblk=1 with out_ready toggled every other cycle -> all 64 bytes delivered in order, none duplicated, out_data stable while stalled.
REQ-039 rst asserted at WRITE byte 10 -> strobes and data go to 0 within the same cycle; after release, state is IDLE and cmd_ready=1.
REQ-040 cmd_valid asserted during DRAIN -> cmd_ready=0 and the command is not accepted until IDLE.
